// File: rtl/hazard_unit_md.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_md
// Description : Tnew/Tuse RAW hazard unit for the 5-stage MIPS pipeline.
//               Selects forwarded operands for D, E and M; raises a stall
//               (freeze PC and IF/ID, bubble ID/EX) when a needed value is
//               not ready in time or the mult/div unit is occupied; tracks
//               mult/div busy time and counts stall cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit_md #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic             rs_use_d,
  input  logic             rt_use_d,
  input  logic [TW-1:0]    tuse_rs_d,
  input  logic [TW-1:0]    tuse_rt_d,
  input  logic [DW-1:0]    rdata1_d,
  input  logic [DW-1:0]    rdata2_d,
  input  logic             md_use_d,
  input  logic [AW-1:0]    rs_e,
  input  logic [AW-1:0]    rt_e,
  input  logic [DW-1:0]    rs_val_e,
  input  logic [DW-1:0]    rt_val_e,
  input  logic [AW-1:0]    waddr_e,
  input  logic [AW-1:0]    waddr_m,
  input  logic [AW-1:0]    waddr_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic [TW-1:0]    tnew_e,
  input  logic [TW-1:0]    tnew_m,
  input  logic [DW-1:0]    wdata_e,
  input  logic [DW-1:0]    wdata_m,
  input  logic [DW-1:0]    wdata_w,
  input  logic             md_start_e,
  input  logic             md_div_e,
  input  logic [AW-1:0]    rt_m,
  input  logic [DW-1:0]    rt_val_m,
  input  logic             stall_cnt_clr,
  output logic [DW-1:0]    fwd_rs_d,
  output logic [DW-1:0]    fwd_rt_d,
  output logic [DW-1:0]    fwd_rs_e,
  output logic [DW-1:0]    fwd_rt_e,
  output logic [DW-1:0]    fwd_rt_m,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Busy counter must hold the longer of the two latencies.
  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MDW    = $clog2(MD_MAX + 1);

  // A stage supplies register a only if it writes it and a is not $0.
  function automatic logic hit(input logic we, input logic [AW-1:0] wa,
                               input logic [AW-1:0] a);
    return we && (wa == a) && (a != '0);
  endfunction

  // Youngest matching stage owns the value; if it is not ready yet, fall back
  // to the default rather than an older (stale) producer.
  function automatic logic [DW-1:0] pick(
    input logic he, input logic re, input logic [DW-1:0] de,
    input logic hm, input logic rm, input logic [DW-1:0] dm,
    input logic hw, input logic [DW-1:0] dw, input logic [DW-1:0] dflt);
    if (he)      return re ? de : dflt;
    else if (hm) return rm ? dm : dflt;
    else if (hw) return dw;
    else         return dflt;
  endfunction

  logic w_e_rs_d, w_m_rs_d, w_w_rs_d;
  logic w_e_rt_d, w_m_rt_d, w_w_rt_d;
  logic w_m_rs_e, w_w_rs_e, w_m_rt_e, w_w_rt_e, w_w_rt_m;
  logic w_data_stall, w_md_stall, w_stall;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Per-stage address matches.
  always_comb begin
    w_e_rs_d = hit(regwrite_e, waddr_e, rs_d);
    w_m_rs_d = hit(regwrite_m, waddr_m, rs_d);
    w_w_rs_d = hit(regwrite_w, waddr_w, rs_d);
    w_e_rt_d = hit(regwrite_e, waddr_e, rt_d);
    w_m_rt_d = hit(regwrite_m, waddr_m, rt_d);
    w_w_rt_d = hit(regwrite_w, waddr_w, rt_d);
    w_m_rs_e = hit(regwrite_m, waddr_m, rs_e);
    w_w_rs_e = hit(regwrite_w, waddr_w, rs_e);
    w_m_rt_e = hit(regwrite_m, waddr_m, rt_e);
    w_w_rt_e = hit(regwrite_w, waddr_w, rt_e);
    w_w_rt_m = hit(regwrite_w, waddr_w, rt_m);
  end

  // Operand forwarding muxes for D, E and M.
  always_comb begin
    fwd_rs_d = pick(w_e_rs_d, tnew_e == '0, wdata_e, w_m_rs_d, tnew_m == '0,
                    wdata_m, w_w_rs_d, wdata_w, rdata1_d);
    fwd_rt_d = pick(w_e_rt_d, tnew_e == '0, wdata_e, w_m_rt_d, tnew_m == '0,
                    wdata_m, w_w_rt_d, wdata_w, rdata2_d);
    fwd_rs_e = pick(1'b0, 1'b0, wdata_e, w_m_rs_e, tnew_m == '0,
                    wdata_m, w_w_rs_e, wdata_w, rs_val_e);
    fwd_rt_e = pick(1'b0, 1'b0, wdata_e, w_m_rt_e, tnew_m == '0,
                    wdata_m, w_w_rt_e, wdata_w, rt_val_e);
    fwd_rt_m = w_w_rt_m ? wdata_w : rt_val_m;
  end

  // Stall when an operand is needed before its producer delivers it, or when
  // a mult/div-related instruction would collide with a running operation.
  always_comb begin
    w_data_stall = (rs_use_d && w_e_rs_d && (tuse_rs_d < tnew_e)) ||
                   (rs_use_d && w_m_rs_d && (tuse_rs_d < tnew_m)) ||
                   (rt_use_d && w_e_rt_d && (tuse_rt_d < tnew_e)) ||
                   (rt_use_d && w_m_rt_d && (tuse_rt_d < tnew_m));
    w_md_stall   = md_use_d && (md_busy || md_start_e);
    w_stall      = w_data_stall || w_md_stall;
    pc_en        = !w_stall;
    if_id_en     = !w_stall;
    id_ex_clr    = w_stall;
  end

  // Next-state for the mult/div busy counter and the stall counter.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e && (md_cnt_q == '0))
      md_cnt_d = md_div_e ? MDW'(DIV_CYCLES) : MDW'(MULT_CYCLES);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr)
      stall_cnt_d = '0;
    else if (w_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_md
// Description : Directed, table-driven bench for hazard_unit_md plus
//               hand-written sequences for mult/div timing, the stall
//               counter and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_md;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs_d, rt_d, rs_e, rt_e, waddr_e, waddr_m, waddr_w, rt_m;
  logic          rs_use_d, rt_use_d, md_use_d;
  logic          regwrite_e, regwrite_m, regwrite_w;
  logic [1:0]    tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic [31:0]   rdata1_d, rdata2_d, rs_val_e, rt_val_e;
  logic [31:0]   wdata_e, wdata_m, wdata_w, rt_val_m;
  logic          md_start_e, md_div_e, stall_cnt_clr;
  logic [31:0]   fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic          pc_en, if_id_en, id_ex_clr, md_busy;
  logic [CW-1:0] stall_cnt;

  hazard_unit_md #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_use_d(rs_use_d), .rt_use_d(rt_use_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .rdata1_d(rdata1_d), .rdata2_d(rdata2_d), .md_use_d(md_use_d),
    .rs_e(rs_e), .rt_e(rt_e), .rs_val_e(rs_val_e), .rt_val_e(rt_val_e),
    .waddr_e(waddr_e), .waddr_m(waddr_m), .waddr_w(waddr_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .tnew_e(tnew_e), .tnew_m(tnew_m),
    .wdata_e(wdata_e), .wdata_m(wdata_m), .wdata_w(wdata_w),
    .md_start_e(md_start_e), .md_div_e(md_div_e),
    .rt_m(rt_m), .rt_val_m(rt_val_m), .stall_cnt_clr(stall_cnt_clr),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs_d, rs_use, tuse_rs, rt_d, rt_use, tuse_rt;
    int waddr_e, rw_e, tnew_e, wd_e;
    int waddr_m, rw_m, tnew_m, wd_m;
    int waddr_w, rw_w, wd_w;
    int rs_e, rt_m;
    int x_rs_d, x_rt_d, x_rs_e, x_rt_m, x_stall;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle();
    rs_d = '0; rt_d = '0; rs_use_d = 1'b0; rt_use_d = 1'b0;
    tuse_rs_d = '0; tuse_rt_d = '0; md_use_d = 1'b0;
    rdata1_d = 32'hD1; rdata2_d = 32'hD2;
    rs_e = '0; rt_e = '0; rs_val_e = 32'hE1; rt_val_e = 32'hE2;
    waddr_e = '0; waddr_m = '0; waddr_w = '0;
    regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    tnew_e = '0; tnew_m = '0;
    wdata_e = '0; wdata_m = '0; wdata_w = '0;
    md_start_e = 1'b0; md_div_e = 1'b0;
    rt_m = '0; rt_val_m = 32'hF3; stall_cnt_clr = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    rs_d = 5'(v.rs_d); rs_use_d = v.rs_use[0]; tuse_rs_d = 2'(v.tuse_rs);
    rt_d = 5'(v.rt_d); rt_use_d = v.rt_use[0]; tuse_rt_d = 2'(v.tuse_rt);
    waddr_e = 5'(v.waddr_e); regwrite_e = v.rw_e[0]; tnew_e = 2'(v.tnew_e);
    wdata_e = 32'(v.wd_e);
    waddr_m = 5'(v.waddr_m); regwrite_m = v.rw_m[0]; tnew_m = 2'(v.tnew_m);
    wdata_m = 32'(v.wd_m);
    waddr_w = 5'(v.waddr_w); regwrite_w = v.rw_w[0]; wdata_w = 32'(v.wd_w);
    rs_e = 5'(v.rs_e); rt_m = 5'(v.rt_m);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_stall();
    rs_d = 5'd1; rs_use_d = 1'b1; tuse_rs_d = 2'd0;
    waddr_e = 5'd1; regwrite_e = 1'b1; tnew_e = 2'd2;
  endtask

  initial begin
    // rs_d use tuse | rt_d use tuse | E: waddr rw tnew data | M: waddr rw tnew data
    // | W: waddr rw data | rs_e rt_m | exp rs_d rt_d rs_e rt_m stall
    vecs[0]  = '{1,1,1, 0,0,0, 1,1,2,'hDEAD, 0,0,0,0, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,1};
    vecs[1]  = '{1,1,1, 0,0,0, 0,0,0,0, 1,1,1,'hDEAD, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,0};
    vecs[2]  = '{1,1,0, 0,0,0, 0,0,0,0, 1,1,1,'hDEAD, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,1};
    vecs[3]  = '{1,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 1,1,'h1234, 0,0, 'h1234,'hD2,'hE1,'hF3,0};
    vecs[4]  = '{31,1,0, 0,0,0, 31,1,0,'h3010, 0,0,0,0, 0,0,0, 0,0, 'h3010,'hD2,'hE1,'hF3,0};
    vecs[5]  = '{0,0,0, 0,0,0, 0,0,0,0, 5,1,0,'hAAAA, 5,1,'hBBBB, 5,0, 'hD1,'hD2,'hAAAA,'hF3,0};
    vecs[6]  = '{0,0,0, 0,0,0, 0,0,0,0, 5,0,0,'hAAAA, 5,1,'hBBBB, 5,0, 'hD1,'hD2,'hBBBB,'hF3,0};
    vecs[7]  = '{0,1,0, 0,1,0, 0,1,2,'h1111, 0,1,0,'h5555, 0,1,'h6666, 0,0, 'hD1,'hD2,'hE1,'hF3,0};
    vecs[8]  = '{3,1,1, 0,0,0, 3,1,1,'h3333, 3,1,0,'hAAAA, 3,1,'hBBBB, 3,0, 'hD1,'hD2,'hAAAA,'hF3,0};
    vecs[9]  = '{0,0,0, 0,0,0, 0,0,0,0, 3,1,1,'hAAAA, 3,1,'hBBBB, 3,0, 'hD1,'hD2,'hE1,'hF3,0};
    vecs[10] = '{0,0,0, 7,1,0, 0,0,0,0, 7,1,1,'h77, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,1};
    vecs[11] = '{0,0,0, 7,1,2, 0,0,0,0, 7,1,0,'h77, 7,1,'h99, 0,7, 'hD1,'h77,'hE1,'h99,0};
    vecs[12] = '{1,0,0, 0,0,0, 1,1,2,'hDEAD, 0,0,0,0, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,0};
    vecs[13] = '{0,0,0, 9,1,1, 9,1,3,'h9, 0,0,0,0, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,1};
    vecs[14] = '{0,0,0, 9,1,2, 9,1,2,'h9, 0,0,0,0, 0,0,0, 0,0, 'hD1,'hD2,'hE1,'hF3,0};

    // Reset state; combinational path live during reset.
    idle();
    rst_n = 1'b0;
    #12;
    chk("reset md_busy", 32'(md_busy), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset pc_en", 32'(pc_en), 32'd1);
    rst_n = 1'b1;
    next_cycle();

    // Table-driven forwarding / data-stall vectors.
    for (int i = 0; i < NV; i++) begin
      idle();
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d fwd_rs_d", i), fwd_rs_d, 32'(vecs[i].x_rs_d));
      chk($sformatf("v%0d fwd_rt_d", i), fwd_rt_d, 32'(vecs[i].x_rt_d));
      chk($sformatf("v%0d fwd_rs_e", i), fwd_rs_e, 32'(vecs[i].x_rs_e));
      chk($sformatf("v%0d fwd_rt_e", i), fwd_rt_e, 32'hE2);
      chk($sformatf("v%0d fwd_rt_m", i), fwd_rt_m, 32'(vecs[i].x_rt_m));
      chk($sformatf("v%0d pc_en", i), 32'(pc_en), 32'(vecs[i].x_stall == 0));
      chk($sformatf("v%0d if_id_en", i), 32'(if_id_en), 32'(vecs[i].x_stall == 0));
      chk($sformatf("v%0d id_ex_clr", i), 32'(id_ex_clr), 32'(vecs[i].x_stall));
      next_cycle();
    end

    // Stall counter: clear, count 3, clear, clear-beats-increment, saturate.
    idle();
    stall_cnt_clr = 1'b1;
    next_cycle();
    stall_cnt_clr = 1'b0;
    chk("cnt cleared", 32'(stall_cnt), 32'd0);
    set_data_stall();
    repeat (3) next_cycle();
    idle();
    @(negedge clk);
    chk("cnt three", 32'(stall_cnt), 32'd3);
    next_cycle();
    chk("cnt hold", 32'(stall_cnt), 32'd3);
    set_data_stall();
    stall_cnt_clr = 1'b1;
    next_cycle();
    stall_cnt_clr = 1'b0;
    chk("cnt clr priority", 32'(stall_cnt), 32'd0);
    repeat (20) next_cycle();
    chk("cnt saturate", 32'(stall_cnt), 32'd15);
    idle();
    next_cycle();

    // div at cycle t with mflo in D: stall t..t+10, busy t+1..t+10.
    md_start_e = 1'b1; md_div_e = 1'b1; md_use_d = 1'b1;
    @(negedge clk);
    chk("div t stall", 32'(pc_en), 32'd0);
    chk("div t busy", 32'(md_busy), 32'd0);
    next_cycle();
    md_start_e = 1'b0; md_div_e = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("div t+%0d busy", k), 32'(md_busy), 32'd1);
      chk($sformatf("div t+%0d stall", k), 32'(id_ex_clr), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("div t+11 busy", 32'(md_busy), 32'd0);
    chk("div t+11 go", 32'(pc_en), 32'd1);
    next_cycle();

    // mult: busy t+1..t+5, no mflo waiting.
    md_use_d = 1'b0;
    md_start_e = 1'b1;
    next_cycle();
    md_start_e = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("mult t+%0d busy", k), 32'(md_busy), 32'd1);
      chk($sformatf("mult t+%0d pc_en", k), 32'(pc_en), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("mult t+6 busy", 32'(md_busy), 32'd0);
    next_cycle();

    // Asynchronous reset in the middle of a divide.
    md_start_e = 1'b1; md_div_e = 1'b1;
    next_cycle();
    md_start_e = 1'b0; md_div_e = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("pre-reset busy", 32'(md_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(md_busy), 32'd0);
    chk("async rst cnt", 32'(stall_cnt), 32'd0);
    md_use_d = 1'b1;
    #1;
    chk("rst md stall off", 32'(pc_en), 32'd1);
    md_use_d = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post-rst busy", 32'(md_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
